// File: rtl/amcal3_8bit_mult_core.sv
// AMCAL3 approximate multiplier back end: multiplies the LOD mantissas, sums the
// leading-one positions, and realigns the product in a 2-stage valid/ready pipe.
module amcal3_8bit_mult_core #(
    parameter int MANT_W  = 3,
    parameter int SHIFT_W = 3,
    parameter int OUT_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MANT_W-1:0]  a,
    input  logic [MANT_W-1:0]  b,
    input  logic [SHIFT_W-1:0] ashift,
    input  logic [SHIFT_W-1:0] bshift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   prod,
    output logic               prod_zero,
    output logic [CNT_W-1:0]   prod_cnt
);

    localparam int MW      = 2 * MANT_W;
    localparam int SW      = SHIFT_W + 1;
    localparam int PW      = MW + 2 * ((1 << SHIFT_W) - 1);
    // Each operand is (m << shift) >> 2, so the product carries a >> 4.
    localparam int FRAC_SH = 4;

    logic          v1;
    logic          v2;
    logic [MW-1:0] m1;
    logic [SW-1:0] s1;
    logic          z1;
    logic          accept;
    logic          adv2;
    logic          out_hs;
    logic [PW-1:0] wide;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; producers hold data while valid & !ready. in_ready depends
    // combinationally on out_ready so a full pipe can still take a new input
    // in the cycle its head drains.
    assign in_ready  = !v1 || !v2 || out_ready;
    assign accept    = in_valid && in_ready;
    assign adv2      = v1 && (!v2 || out_ready);
    assign out_hs    = v2 && out_ready;
    assign out_valid = v2;

    always_comb begin
        wide = PW'(m1) << s1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            m1 <= '0;
            s1 <= '0;
            z1 <= 1'b0;
        end else begin
            if (accept) begin
                v1 <= 1'b1;
                m1 <= MW'(a) * MW'(b);
                s1 <= SW'(ashift) + SW'(bshift);
                z1 <= (a == '0) || (b == '0);
            end else if (adv2) begin
                v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            prod      <= '0;
            prod_zero <= 1'b0;
        end else begin
            if (adv2) begin
                v2        <= 1'b1;
                prod      <= z1 ? '0 : OUT_W'(wide >> FRAC_SH);
                prod_zero <= z1;
            end else if (out_hs) begin
                v2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_cnt <= '0;
        end else if (out_hs) begin
            prod_cnt <= prod_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_amcal3_8bit_mult_core.sv
// Bench for amcal3_8bit_mult_core: fixed vectors, backpressure and reset
// sequences, and a long random stream scored against an arithmetic model.
module tb_amcal3_8bit_mult_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  ashift;
    logic [2:0]  bshift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        prod_zero;
    logic [15:0] prod_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;
    logic [16:0] exp_q[$];
    logic [16:0] e;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  as;
        logic [2:0]  bs;
        logic [15:0] prod;
        logic        zero;
    } vec_t;

    vec_t tv[9];
    logic [2:0] bpa[4];
    logic [2:0] bpb[4];
    logic [2:0] bpas[4];
    logic [2:0] bpbs[4];

    amcal3_8bit_mult_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ashift    (ashift),
        .bshift    (bshift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .prod_zero (prod_zero),
        .prod_cnt  (prod_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Operand value is (m * 2^shift) / 4; product is their exact product / 16
    // before truncation, i.e. m_a*m_b*2^(sa+sb)/16 rounded down.
    function automatic logic [16:0] ref_model(input int ma, input int mb, input int sa, input int sb);
        int p;
        if (ma == 0 || mb == 0) return {1'b1, 16'd0};
        p = (ma * mb * (1 << (sa + sb))) / 16;
        return {1'b0, p[15:0]};
    endfunction

    function automatic logic [2:0] rand_mant();
        if ($urandom_range(0, 9) == 0) return 3'd0;
        return 3'($urandom_range(4, 7));
    endfunction

    task automatic drive(input logic [2:0] x, input logic [2:0] y, input logic [2:0] xs, input logic [2:0] ys);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        ashift   = xs;
        bshift   = ys;
    endtask

    task automatic drive_rand();
        drive(rand_mant(), rand_mant(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        exp_cnt = 0;
        next_cycle();
    endtask

    task automatic stream(input int n, input int ready_pct, input int valid_pct, input int bound);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < bound) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if ($urandom_range(0, 99) < valid_pct) drive_rand();
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            next_cycle();
            cyc++;
        end
        check("stream_all_sent", sent, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 20) begin
            next_cycle();
            cyc++;
        end
        check("stream_drained", exp_q.size(), 0);
        exp_cnt = (exp_cnt + n) % 65536;
    endtask

    // Scoreboard: record every accepted input, compare every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_queue_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_prod", int'(prod), int'(e[15:0]));
                    check("sb_zero", int'(prod_zero), int'(e[16]));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(int'(a), int'(b), int'(ashift), int'(bshift)));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx;
        int hs_seen;
        logic [15:0] held;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; ashift = '0; bshift = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_prod", int'(prod), 0);
        check("rst_prod_zero", int'(prod_zero), 0);
        check("rst_prod_cnt", int'(prod_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        next_cycle();

        tv[0] = '{3'd4, 3'd4, 3'd0, 3'd0, 16'd1,     1'b0};
        tv[1] = '{3'd6, 3'd6, 3'd7, 3'd6, 16'd18432, 1'b0};
        tv[2] = '{3'd7, 3'd7, 3'd7, 3'd7, 16'd50176, 1'b0};
        tv[3] = '{3'd0, 3'd7, 3'd0, 3'd7, 16'd0,     1'b1};
        tv[4] = '{3'd4, 3'd4, 3'd0, 3'd0, 16'd1,     1'b0};
        tv[5] = '{3'd5, 3'd7, 3'd3, 3'd1, 16'd35,    1'b0};
        tv[6] = '{3'd4, 3'd5, 3'd0, 3'd0, 16'd1,     1'b0};
        tv[7] = '{3'd7, 3'd6, 3'd2, 3'd0, 16'd10,    1'b0};
        tv[8] = '{3'd7, 3'd0, 3'd7, 3'd7, 16'd0,     1'b1};

        // Single transactions: exact 2-cycle latency and value.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].a, tv[i].b, tv[i].as, tv[i].bs);
            @(negedge clk);
            check("tv_in_ready", int'(in_ready), 1);
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            check("tv_lat1_not_valid", int'(out_valid), 0);
            next_cycle();
            @(negedge clk);
            check("tv_valid", int'(out_valid), 1);
            check("tv_prod", int'(prod), int'(tv[i].prod));
            check("tv_zero", int'(prod_zero), int'(tv[i].zero));
            next_cycle();
            exp_cnt++;
        end
        @(negedge clk);
        check("tv_prod_cnt", int'(prod_cnt), exp_cnt);
        next_cycle();

        // Backpressure: a stalled consumer lets exactly two inputs in.
        for (int i = 0; i < 4; i++) begin
            bpa[i] = rand_mant();
            bpb[i] = rand_mant();
            bpas[i] = 3'($urandom_range(0, 7));
            bpbs[i] = 3'($urandom_range(0, 7));
        end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(bpa[idx], bpb[idx], bpas[idx], bpbs[idx]);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        check("bp_accepted", idx, 2);
        @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid_held", int'(out_valid), 1);
        held = prod;
        next_cycle();
        @(negedge clk);
        check("bp_prod_stable", int'(prod), int'(held));
        check("bp_still_valid", int'(out_valid), 1);
        next_cycle();
        out_ready = 1'b1;
        hs_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 4) drive(bpa[idx], bpb[idx], bpas[idx], bpbs[idx]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) hs_seen++;
            next_cycle();
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 4);
        check("bp_one_per_cycle", hs_seen, 4);
        exp_cnt += 4;
        @(negedge clk);
        check("bp_drained", int'(out_valid), 0);
        check("bp_prod_cnt", int'(prod_cnt), exp_cnt);
        next_cycle();

        // Async reset with both stages full, off the clock edge.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            next_cycle();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_prod_cnt", int'(prod_cnt), 0);
        check("arst_prod", int'(prod), 0);
        check("arst_in_ready", int'(in_ready), 1);
        exp_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("arst_no_ghost", int'(out_valid), 0);
        next_cycle();
        out_ready = 1'b1;
        drive(3'd4, 3'd4, 3'd0, 3'd0);
        @(negedge clk);
        check("arst_accept", int'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("arst_lat1", int'(out_valid), 0);
        next_cycle();
        @(negedge clk);
        check("arst_lat2_valid", int'(out_valid), 1);
        check("arst_lat2_prod", int'(prod), 1);
        next_cycle();
        exp_cnt++;

        // Random streaming with random backpressure.
        do_reset();
        stream(1000, 50, 75, 10000);
        @(negedge clk);
        check("stream_prod_cnt", int'(prod_cnt), exp_cnt);
        next_cycle();

        // Counter wrap: fill to all-ones, then one more handshake.
        stream(64535, 100, 100, 70000);
        @(negedge clk);
        check("cnt_max", int'(prod_cnt), 65535);
        next_cycle();
        stream(1, 100, 100, 10);
        @(negedge clk);
        check("cnt_wrap", int'(prod_cnt), exp_cnt);
        check("cnt_wrap_zero", int'(prod_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
